// File: rtl/nourishment_scheduler_pkg.sv
// Shared types for the nourishment scheduler: FSM states, action priority and consumer count.
// Pure declarations; no timing or backpressure of its own.
package nourishment_scheduler_pkg;

  localparam int NUM_CONSUMERS = 4;
  localparam int PTR_W         = $clog2(NUM_CONSUMERS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIGEST   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  // Ordered from highest to lowest priority after ACT_NONE.
  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_REVIVE = 3'd1,
    ACT_DIGEST = 3'd2,
    ACT_GRANT  = 3'd3,
    ACT_BASAL  = 3'd4
  } action_t;

  function automatic logic [PTR_W-1:0] oh_to_idx(input logic [NUM_CONSUMERS-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      if (oh[k]) idx = PTR_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/nourishment_scheduler_if.sv
// Command/feedback bundle between the nourishment system, consumers and the scheduler.
// The scheduler side is the slave modport; the environment drives through master.
interface nourishment_scheduler_if;
  import nourishment_scheduler_pkg::*;

  logic                     meal;
  logic                     big_meal;
  logic                     revive;
  logic                     starving;
  logic [NUM_CONSUMERS-1:0] req;
  logic [NUM_CONSUMERS-1:0] gnt;
  logic                     inc;
  logic                     dec;
  logic                     fast;
  logic                     setval;
  logic                     busy;

  modport master (
    output meal, big_meal, revive, starving, req,
    input  gnt, inc, dec, fast, setval, busy
  );

  modport slave (
    input  meal, big_meal, revive, starving, req,
    output gnt, inc, dec, fast, setval, busy
  );

endinterface

// File: rtl/nourishment_scheduler_rr_arbiter4.sv
// Combinational round-robin picker: first requester at or after ptr, modulo 4.
// Zero latency; o_vld low when nothing requests.
module rr_arbiter4
  import nourishment_scheduler_pkg::*;
(
  input  logic [NUM_CONSUMERS-1:0] i_req,
  input  logic [PTR_W-1:0]         i_ptr,
  output logic [NUM_CONSUMERS-1:0] o_gnt,
  output logic                     o_vld
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_vld = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      w_idx = i_ptr + PTR_W'(k);
      if (!o_vld && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_vld        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nourishment_scheduler.sv
// Tick-paced scheduler issuing one glucose command per slot: revive > digestion > grant > basal.
// Commands appear one cycle after the tick; no backpressure, meals outside IDLE are dropped.
module nourishment_scheduler
  import nourishment_scheduler_pkg::*;
#(
  parameter int TICK_DIV       = 256,
  parameter int MEAL_STEPS     = 16,
  parameter int COOLDOWN_TICKS = 8,
  parameter int BASAL_DIV      = 4
)(
  input logic                    clk,
  input logic                    rst,
  nourishment_scheduler_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t                   r_state, w_state_nxt;
  logic [PW-1:0]            r_presc;
  logic [7:0]               r_cnt, w_cnt_nxt;
  logic                     r_fast_flag, w_fast_flag_nxt;
  logic                     r_rev_pend;
  logic [7:0]               r_basal;
  logic [PTR_W-1:0]         r_ptr;
  logic [NUM_CONSUMERS-1:0] r_gnt, w_gnt;
  logic                     r_inc, r_dec, r_fast, r_setval, r_busy;
  logic                     w_inc, w_dec, w_fast, w_setval;
  logic                     w_tick, w_basal_hit, w_arb_vld;
  logic [NUM_CONSUMERS-1:0] w_arb_gnt;
  action_t                  w_act;

  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
  assign w_basal_hit = ({24'd0, r_basal} + 32'd1) >= 32'(BASAL_DIV);

  rr_arbiter4 u_arb (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_vld (w_arb_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A serviced revive overrides everything, including a meal arriving on that tick.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_fast_flag_nxt = r_fast_flag;
    if (w_tick && r_rev_pend) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.meal) begin
          w_state_nxt     = ST_DIGEST;
          w_cnt_nxt       = 8'(MEAL_STEPS);
          w_fast_flag_nxt = bus.big_meal;
        end
        ST_DIGEST: if (w_tick) begin
          w_cnt_nxt = r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            w_state_nxt = ST_COOLDOWN;
            w_cnt_nxt   = 8'(COOLDOWN_TICKS);
          end
        end
        ST_COOLDOWN: if (w_tick) begin
          w_cnt_nxt = r_cnt - 8'd1;
          if (r_cnt == 8'd1) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_act = ACT_NONE;
    if (w_tick) begin
      if (r_rev_pend)                    w_act = ACT_REVIVE;
      else if (r_state == ST_DIGEST)     w_act = ACT_DIGEST;
      else if (!bus.starving && w_arb_vld) w_act = ACT_GRANT;
      else                               w_act = ACT_BASAL;
    end
    w_inc    = (w_act == ACT_DIGEST);
    w_dec    = (w_act == ACT_GRANT) || ((w_act == ACT_BASAL) && w_basal_hit);
    w_fast   = ((w_act == ACT_DIGEST) && r_fast_flag) || (w_act == ACT_GRANT);
    w_setval = (w_act == ACT_REVIVE);
    w_gnt    = (w_act == ACT_GRANT) ? w_arb_gnt : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_cnt       <= '0;
      r_fast_flag <= 1'b0;
      r_rev_pend  <= 1'b0;
      r_basal     <= '0;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_inc       <= 1'b0;
      r_dec       <= 1'b0;
      r_fast      <= 1'b0;
      r_setval    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_presc     <= w_tick ? '0 : r_presc + PW'(1);
      r_cnt       <= w_cnt_nxt;
      r_fast_flag <= w_fast_flag_nxt;
      // A revive landing on the servicing tick belongs to the following tick.
      if (w_tick && r_rev_pend) r_rev_pend <= bus.revive;
      else if (bus.revive)      r_rev_pend <= 1'b1;
      if (w_act == ACT_BASAL)   r_basal <= w_basal_hit ? 8'd0 : r_basal + 8'd1;
      if (w_act == ACT_GRANT)   r_ptr   <= oh_to_idx(w_arb_gnt) + PTR_W'(1);
      r_gnt    <= w_gnt;
      r_inc    <= w_inc;
      r_dec    <= w_dec;
      r_fast   <= w_fast;
      r_setval <= w_setval;
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.inc    = r_inc;
  assign bus.dec    = r_dec;
  assign bus.fast   = r_fast;
  assign bus.setval = r_setval;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_nourishment_scheduler.sv
// Directed bench for nourishment_scheduler with TICK_DIV=4, MEAL_STEPS=3, COOLDOWN_TICKS=2, BASAL_DIV=2.
// Cycle numbers count rising edges after the first reset release; slot outputs land on multiples of 4.
module tb_nourishment_scheduler;
  import nourishment_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nourishment_scheduler_if bus_if ();

  nourishment_scheduler #(
    .TICK_DIV       (4),
    .MEAL_STEPS     (3),
    .COOLDOWN_TICKS (2),
    .BASAL_DIV      (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;
  int viol  = 0;
  int n_inc, n_incfast, n_dec, n_decfast, n_decslow, n_set, n_gnt, n_busy;
  int first_gnt, first_dec;
  int inc_cyc[$];
  int gnt_idx[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clr();
    n_inc = 0; n_incfast = 0; n_dec = 0; n_decfast = 0; n_decslow = 0;
    n_set = 0; n_gnt = 0; n_busy = 0; first_gnt = -1; first_dec = -1;
    inc_cyc.delete();
    gnt_idx.delete();
  endtask

  // Advance n cycles, sampling 1ns after each rising edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (bus_if.inc === 1'b1) begin
        n_inc++;
        inc_cyc.push_back(cyc_no);
        if (bus_if.fast === 1'b1) n_incfast++;
      end
      if (bus_if.dec === 1'b1) begin
        n_dec++;
        if (bus_if.fast === 1'b1) n_decfast++; else n_decslow++;
        if (first_dec < 0) first_dec = cyc_no;
      end
      if (bus_if.setval === 1'b1) n_set++;
      if (bus_if.busy === 1'b1) n_busy++;
      if (bus_if.gnt !== 4'b0000) begin
        n_gnt++;
        gnt_idx.push_back(int'(oh_to_idx(bus_if.gnt)));
        if (first_gnt < 0) first_gnt = cyc_no;
      end
      if ((bus_if.inc && bus_if.dec) || (bus_if.setval && (bus_if.inc || bus_if.dec)) ||
          ($countones(bus_if.gnt) > 1) || ((bus_if.gnt != 4'b0000) && !(bus_if.dec && bus_if.fast)))
        viol++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.meal = 1'b0; bus_if.big_meal = 1'b0; bus_if.revive = 1'b0;
    bus_if.starving = 1'b1; bus_if.req = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt",    32'(bus_if.gnt),    0);
    chk("rst_inc",    32'(bus_if.inc),    0);
    chk("rst_dec",    32'(bus_if.dec),    0);
    chk("rst_fast",   32'(bus_if.fast),   0);
    chk("rst_setval", 32'(bus_if.setval), 0);
    chk("rst_busy",   32'(bus_if.busy),   0);

    // Starving with all requesting: only basal decs, every second slot.
    rst = 1'b0;
    clr();
    cyc(16);
    chk("starve_gnt",       n_gnt,     0);
    chk("starve_dec",       n_dec,     2);
    chk("starve_dec_slow",  n_decslow, 2);
    chk("starve_first_dec", first_dec, 8);

    // Round robin over req=1011.
    clr();
    bus_if.starving = 1'b0; bus_if.req = 4'b1011;
    cyc(16);
    chk("rr_count",     n_gnt,            4);
    chk("rr_first_cyc", first_gnt,        20);
    chk("rr_g0",        qget(gnt_idx, 0), 0);
    chk("rr_g1",        qget(gnt_idx, 1), 1);
    chk("rr_g2",        qget(gnt_idx, 2), 3);
    chk("rr_g3",        qget(gnt_idx, 3), 0);
    chk("rr_dec_fast",  n_decfast,        4);

    // Big meal with a second meal during digestion.
    clr();
    bus_if.req = 4'b0000;
    bus_if.meal = 1'b1; bus_if.big_meal = 1'b1;
    cyc(1);
    bus_if.meal = 1'b0; bus_if.big_meal = 1'b0;
    chk("meal_busy_start", 32'(bus_if.busy), 1);
    cyc(4);
    bus_if.meal = 1'b1;
    cyc(1);
    bus_if.meal = 1'b0;
    cyc(13);
    chk("meal_busy_cool", 32'(bus_if.busy), 1);
    cyc(1);
    chk("meal_busy_end",  32'(bus_if.busy), 0);
    cyc(8);
    chk("meal_inc",      n_inc,            3);
    chk("meal_inc_fast", n_incfast,        3);
    chk("meal_inc0",     qget(inc_cyc, 0), 36);
    chk("meal_inc1",     qget(inc_cyc, 1), 40);
    chk("meal_inc2",     qget(inc_cyc, 2), 44);

    // Revive during digestion.
    clr();
    bus_if.meal = 1'b1; bus_if.big_meal = 1'b0;
    cyc(1);
    bus_if.meal = 1'b0;
    cyc(4);
    bus_if.revive = 1'b1;
    cyc(1);
    bus_if.revive = 1'b0;
    cyc(1);
    chk("rev_busy_before", 32'(bus_if.busy),   1);
    cyc(1);
    chk("rev_setval",      32'(bus_if.setval), 1);
    chk("rev_inc",         32'(bus_if.inc),    0);
    chk("rev_busy_after",  32'(bus_if.busy),   0);
    cyc(12);
    chk("rev_total_inc",   n_inc,              1);
    chk("rev_inc_slow",    n_incfast,          0);
    chk("rev_inc_cyc",     qget(inc_cyc, 0),   64);
    chk("rev_setval_cnt",  n_set,              1);

    // One-cycle reset in the middle of digestion.
    clr();
    bus_if.meal = 1'b1; bus_if.big_meal = 1'b1;
    cyc(1);
    bus_if.meal = 1'b0; bus_if.big_meal = 1'b0;
    cyc(3);
    chk("mid_inc_before", 32'(bus_if.inc), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_inc",  32'(bus_if.inc),  0);
    chk("mid_rst_fast", 32'(bus_if.fast), 0);
    chk("mid_rst_busy", 32'(bus_if.busy), 0);
    cyc(1);
    rst = 1'b0;
    bus_if.req = 4'b0001;
    clr();
    cyc(20);
    chk("post_rst_first_gnt", first_gnt, 89);
    chk("post_rst_gnt_cnt",   n_gnt,     5);
    chk("post_rst_inc",       n_inc,     0);
    chk("post_rst_busy",      n_busy,    0);

    clr();
    bus_if.req = 4'b0000;
    bus_if.meal = 1'b1;
    cyc(1);
    bus_if.meal = 1'b0;
    cyc(24);
    chk("new_meal_inc",      n_inc,            3);
    chk("new_meal_inc_slow", n_incfast,        0);
    chk("new_meal_inc0",     qget(inc_cyc, 0), 109);

    chk("invariants", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
